// File: rtl/cpc_serial_card_if.sv
// Z80 expansion-port bus as seen by the serial card: address, data, strobes and interrupt.
// The host CPU side uses the master modport and the card uses the slave modport.
interface cpc_serial_card_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        iorq;
    logic        rd;
    logic        wr;
    logic        m1;
    logic        irq;

    modport master (
        output cpu_addr, cpu_dout, iorq, rd, wr, m1,
        input  cpu_din, irq
    );

    modport slave (
        input  cpu_addr, cpu_dout, iorq, rd, wr, m1,
        output cpu_din, irq
    );
endinterface

// File: rtl/cpc_serial_card.sv
// 8N1 serial card at &F8DC-&F8DF: 4-deep RX FIFO, TX holding + shift register, 16x baud generator.
// Optional interrupt logic is enabled by defining CPC_SERIAL_IRQ_EN; otherwise irq is tied low.
module cpc_serial_card (
    input  logic             clk,
    input  logic             reset,
    input  logic             phi_en_p,
    cpc_serial_card_if.slave bus,
    input  logic             rxd,
    output logic             txd
);

    localparam logic [7:0]  DIV_RESET = 8'd25;
    localparam logic [13:0] IO_BASE   = {8'hF8, 6'b110111};

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // ---------------------------------------------------------------- bus decode
    logic       sel;
    logic       rd_sel;
    logic       wr_sel;
    logic [1:0] reg_idx;
    logic       wr_seen_reg;
    logic       rd_data_reg;
    logic       wr_pulse;
    logic       wr_data;
    logic       wr_ctrl;
    logic       wr_div;
    logic       pop_req;

    assign sel     = bus.iorq & ~bus.m1 & (bus.cpu_addr[15:2] == IO_BASE);
    assign reg_idx = bus.cpu_addr[1:0];
    assign rd_sel  = sel & bus.rd;
    assign wr_sel  = sel & bus.wr;

    // A held write strobe acts once; reg0 reads pop when the strobe goes away.
    assign wr_pulse = wr_sel & ~wr_seen_reg;
    assign wr_data  = wr_pulse & (reg_idx == 2'd0);
    assign wr_ctrl  = wr_pulse & (reg_idx == 2'd1);
    assign wr_div   = wr_pulse & (reg_idx == 2'd2);
    assign pop_req  = rd_data_reg & ~rd_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_seen_reg <= 1'b0;
            rd_data_reg <= 1'b0;
        end else begin
            wr_seen_reg <= wr_sel;
            rd_data_reg <= rd_sel & (reg_idx == 2'd0);
        end
    end

    // ---------------------------------------------------------------- baud generator
    logic [7:0] div_reg;
    logic [7:0] div_act_reg;
    logic [7:0] baud_cnt_reg;
    logic       tick;

    assign tick = phi_en_p & (baud_cnt_reg == div_act_reg);

    // The active divisor only changes on a tick, so the counter never overshoots it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_reg      <= DIV_RESET;
            div_act_reg  <= DIV_RESET;
            baud_cnt_reg <= 8'd0;
        end else begin
            if (wr_div) begin
                div_reg <= bus.cpu_dout;
            end
            if (tick) begin
                baud_cnt_reg <= 8'd0;
                div_act_reg  <= div_reg;
            end else if (phi_en_p) begin
                baud_cnt_reg <= baud_cnt_reg + 8'd1;
            end
        end
    end

    // ---------------------------------------------------------------- receiver
    logic [1:0] rx_sync_reg;
    logic       rx_bit;
    rx_state_t  rx_state_reg, rx_state_next;
    logic [3:0] rx_tick_reg, rx_tick_next;
    logic [2:0] rx_bit_reg, rx_bit_next;
    logic [7:0] rx_shift_reg, rx_shift_next;
    logic       rx_push;
    logic       framing_set;

    assign rx_bit = rx_sync_reg[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync_reg  <= 2'b11;
            rx_state_reg <= RX_IDLE;
            rx_tick_reg  <= 4'd0;
            rx_bit_reg   <= 3'd0;
            rx_shift_reg <= 8'd0;
        end else begin
            rx_sync_reg  <= {rx_sync_reg[0], rxd};
            rx_state_reg <= rx_state_next;
            rx_tick_reg  <= rx_tick_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
        end
    end

    // Start is confirmed 8 ticks in (mid-bit); every later sample is 16 ticks on.
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_tick_next  = rx_tick_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_push       = 1'b0;
        framing_set   = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                if (tick && !rx_bit) begin
                    rx_state_next = RX_START;
                    rx_tick_next  = 4'd0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_tick_reg == 4'd7) begin
                        rx_tick_next  = 4'd0;
                        rx_bit_next   = 3'd0;
                        rx_state_next = rx_bit ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tick_next = rx_tick_reg + 4'd1;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    rx_tick_next = rx_tick_reg + 4'd1;
                    if (rx_tick_reg == 4'd15) begin
                        rx_shift_next = {rx_bit, rx_shift_reg[7:1]};
                        rx_bit_next   = rx_bit_reg + 3'd1;
                        if (rx_bit_reg == 3'd7) begin
                            rx_state_next = RX_STOP;
                        end
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    rx_tick_next = rx_tick_reg + 4'd1;
                    if (rx_tick_reg == 4'd15) begin
                        rx_state_next = RX_IDLE;
                        rx_push       = rx_bit;
                        framing_set   = ~rx_bit;
                    end
                end
            end
        endcase
    end

    // ---------------------------------------------------------------- RX FIFO
    logic [7:0] fifo_mem [4];
    logic [1:0] fifo_wr_ptr_reg;
    logic [1:0] fifo_rd_ptr_reg;
    logic [2:0] fifo_count_reg;
    logic       fifo_empty;
    logic       fifo_full;
    logic       pop_do;
    logic       push_do;
    logic       overrun_set;

    assign fifo_empty  = (fifo_count_reg == 3'd0);
    assign fifo_full   = (fifo_count_reg == 3'd4);
    assign pop_do      = pop_req & ~fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign push_do     = rx_push & (~fifo_full | pop_do);
    assign overrun_set = rx_push & fifo_full & ~pop_do;

    always_ff @(posedge clk) begin
        if (push_do) begin
            fifo_mem[fifo_wr_ptr_reg] <= rx_shift_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_wr_ptr_reg <= 2'd0;
            fifo_rd_ptr_reg <= 2'd0;
            fifo_count_reg  <= 3'd0;
        end else begin
            if (push_do) begin
                fifo_wr_ptr_reg <= fifo_wr_ptr_reg + 2'd1;
            end
            if (pop_do) begin
                fifo_rd_ptr_reg <= fifo_rd_ptr_reg + 2'd1;
            end
            case ({push_do, pop_do})
                2'b10:   fifo_count_reg <= fifo_count_reg + 3'd1;
                2'b01:   fifo_count_reg <= fifo_count_reg - 3'd1;
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    // ---------------------------------------------------------------- transmitter
    tx_state_t  tx_state_reg, tx_state_next;
    logic [3:0] tx_tick_reg;
    logic [2:0] tx_bit_reg, tx_bit_next;
    logic [7:0] tx_shift_reg, tx_shift_next;
    logic [7:0] hold_reg;
    logic       hold_full_reg;
    logic       hold_take;
    logic       bit_end;

    // Free-running tick counter defines the bit boundaries for the whole transmitter.
    assign bit_end = tick & (tx_tick_reg == 4'd15);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_reg  <= TX_IDLE;
            tx_tick_reg   <= 4'd0;
            tx_bit_reg    <= 3'd0;
            tx_shift_reg  <= 8'd0;
            hold_reg      <= 8'd0;
            hold_full_reg <= 1'b0;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            if (tick) begin
                tx_tick_reg <= tx_tick_reg + 4'd1;
            end
            if (hold_take) begin
                hold_full_reg <= 1'b0;
            end
            if (wr_data && !hold_full_reg) begin
                hold_reg      <= bus.cpu_dout;
                hold_full_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        hold_take     = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                if (bit_end && hold_full_reg) begin
                    tx_state_next = TX_START;
                    tx_shift_next = hold_reg;
                    hold_take     = 1'b1;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    tx_state_next = TX_DATA;
                    tx_bit_next   = 3'd0;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                    tx_bit_next   = tx_bit_reg + 3'd1;
                    if (tx_bit_reg == 3'd7) begin
                        tx_state_next = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    if (hold_full_reg) begin
                        tx_state_next = TX_START;
                        tx_shift_next = hold_reg;
                        hold_take     = 1'b1;
                    end else begin
                        tx_state_next = TX_IDLE;
                    end
                end
            end
        endcase
    end

    // Decoded straight from state so an asynchronous reset idles the line at once.
    always_comb begin
        case (tx_state_reg)
            TX_START: txd = 1'b0;
            TX_DATA:  txd = tx_shift_reg[0];
            default:  txd = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------- status, errors, irq
    logic overrun_reg;
    logic framing_reg;
    logic irq_int;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_reg <= 1'b0;
            framing_reg <= 1'b0;
        end else begin
            if (wr_ctrl && bus.cpu_dout[7]) begin
                overrun_reg <= 1'b0;
                framing_reg <= 1'b0;
            end
            if (overrun_set) begin
                overrun_reg <= 1'b1;
            end
            if (framing_set) begin
                framing_reg <= 1'b1;
            end
        end
    end

`ifdef CPC_SERIAL_IRQ_EN
    logic rx_ie_reg;
    logic tx_ie_reg;
    logic irq_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ie_reg <= 1'b0;
            tx_ie_reg <= 1'b0;
            irq_reg   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                rx_ie_reg <= bus.cpu_dout[0];
                tx_ie_reg <= bus.cpu_dout[1];
            end
            irq_reg <= (rx_ie_reg & ~fifo_empty) | (tx_ie_reg & ~hold_full_reg) | overrun_reg;
        end
    end

    assign irq_int = irq_reg;
`else
    assign irq_int = 1'b0;
`endif

    assign bus.irq = irq_int;

    logic [7:0] status;
    logic [7:0] din_mux;

    assign status = {2'b00, irq_int, framing_reg, overrun_reg,
                     (tx_state_reg == TX_IDLE), ~hold_full_reg, ~fifo_empty};

    // Unselected reads return all-ones because the host ANDs the expansion data bus.
    always_comb begin
        din_mux = 8'hFF;
        if (rd_sel) begin
            case (reg_idx)
                2'd0:    din_mux = fifo_empty ? 8'h00 : fifo_mem[fifo_rd_ptr_reg];
                2'd1:    din_mux = status;
                2'd2:    din_mux = div_reg;
                default: din_mux = 8'hFF;
            endcase
        end
    end

    assign bus.cpu_din = din_mux;

endmodule

// File: tb/tb_cpc_serial_card.sv
// Directed and randomized bench for cpc_serial_card; a queue-based model predicts RX FIFO and status.
// Build with CPC_SERIAL_IRQ_EN defined to exercise the interrupt variant.
module tb_cpc_serial_card;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic phi_en_p = 1'b0;
    logic rxd      = 1'b1;
    logic txd;

    cpc_serial_card_if bus ();

    cpc_serial_card dut (
        .clk      (clk),
        .reset    (reset),
        .phi_en_p (phi_en_p),
        .bus      (bus),
        .rxd      (rxd),
        .txd      (txd)
    );

    always #5 clk = ~clk;
    always @(negedge clk) phi_en_p = ~phi_en_p;

    int unsigned phi_total = 0;
    always @(posedge clk) if (phi_en_p) phi_total++;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] q[$];
    bit m_ov = 0, m_fr = 0, m_rxie = 0, m_txie = 0;

    localparam logic [15:0] A_DATA = 16'hF8DC;
    localparam logic [15:0] A_STAT = 16'hF8DD;
    localparam logic [15:0] A_DIV  = 16'hF8DE;
    localparam int FAST_BIT = 32;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_status();
        logic avail;
        logic irq_e;
        avail = (q.size() != 0);
`ifdef CPC_SERIAL_IRQ_EN
        irq_e = (m_rxie & avail) | m_txie | m_ov;
`else
        irq_e = 1'b0;
`endif
        return {2'b00, irq_e, m_fr, m_ov, 1'b1, 1'b1, avail};
    endfunction

    task automatic wait_phi(input int n);
        int unsigned tgt;
        tgt = phi_total + n;
        while (phi_total < tgt) @(negedge clk);
    endtask

    task automatic wait_until(input int unsigned tgt);
        while (phi_total < tgt) @(negedge clk);
    endtask

    task automatic io_read(input logic [15:0] a, input logic m1, output logic [7:0] d);
        @(negedge clk);
        bus.cpu_addr = a;
        bus.m1       = m1;
        bus.iorq     = 1'b1;
        bus.rd       = 1'b1;
        repeat (2) @(negedge clk);
        d        = bus.cpu_din;
        bus.rd   = 1'b0;
        bus.iorq = 1'b0;
        bus.m1   = 1'b0;
        @(negedge clk);
    endtask

    task automatic io_write(input logic [15:0] a, input logic [7:0] d, input int nclk);
        @(negedge clk);
        bus.cpu_addr = a;
        bus.cpu_dout = d;
        bus.iorq     = 1'b1;
        bus.wr       = 1'b1;
        repeat (nclk) @(negedge clk);
        bus.wr   = 1'b0;
        bus.iorq = 1'b0;
        @(negedge clk);
    endtask

    task automatic ctrl_write(input logic [7:0] d);
        io_write(A_STAT, d, 1);
`ifdef CPC_SERIAL_IRQ_EN
        m_rxie = d[0];
        m_txie = d[1];
`endif
        if (d[7]) begin
            m_ov = 0;
            m_fr = 0;
        end
    endtask

    // Bit-banged 8N1 frame at the fast rate; a bad stop bit is held low for 3/4 of a bit.
    task automatic send_rx(input logic [7:0] b, input bit ok);
        rxd = 1'b0;
        wait_phi(FAST_BIT);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_phi(FAST_BIT);
        end
        rxd = ok;
        wait_phi(ok ? FAST_BIT : 24);
        rxd = 1'b1;
        wait_phi(ok ? 40 : 48);
        if (!ok) m_fr = 1;
        else if (q.size() == 4) m_ov = 1;
        else q.push_back(b);
    endtask

    task automatic check_status(input string tag);
        logic [7:0] d;
        io_read(A_STAT, 1'b0, d);
        check(tag, d, exp_status());
    endtask

    task automatic drain(input string tag);
        logic [7:0] d;
        while (q.size() != 0) begin
            io_read(A_DATA, 1'b0, d);
            check({tag, "_data"}, d, q.pop_front());
        end
        io_read(A_DATA, 1'b0, d);
        check({tag, "_empty"}, d, 8'h00);
        check_status({tag, "_stat_drained"});
        ctrl_write(8'h80);
        check_status({tag, "_stat_cleared"});
    endtask

    task automatic wait_fall(input int max_clk, output bit seen, output int unsigned t);
        seen = 0;
        t    = 0;
        for (int i = 0; i < max_clk && !seen; i++) begin
            @(negedge clk);
            if (txd === 1'b0) begin
                seen = 1;
                t    = phi_total;
            end
        end
    endtask

    task automatic decode_tx(input int unsigned t0, output logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            wait_until(t0 + FAST_BIT / 2 + FAST_BIT * (i + 1));
            b[i] = txd;
        end
        wait_until(t0 + FAST_BIT / 2 + FAST_BIT * 9);
        check("tx_stop", txd, 1'b1);
    endtask

    task automatic recv_tx(output logic [7:0] b, output int unsigned t);
        bit seen;
        wait_fall(4000, seen, t);
        check("tx_start_seen", seen, 1'b1);
        b = 8'h00;
        if (seen) decode_tx(t, b);
    endtask

    initial begin
        logic [7:0]  d, b, b1, b2;
        int unsigned t0, t1, t2;
        bit          seen;
        int          n;

        bus.cpu_addr = '0;
        bus.cpu_dout = '0;
        bus.iorq     = 1'b0;
        bus.rd       = 1'b0;
        bus.wr       = 1'b0;
        bus.m1       = 1'b0;

        // Reset state
        repeat (4) @(negedge clk);
        check("reset_txd", txd, 1'b1);
        check("reset_irq", bus.irq, 1'b0);
        check("reset_din_idle", bus.cpu_din, 8'hFF);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        io_read(A_STAT, 1'b0, d);  check("status_after_reset", d, 8'h06);
        io_read(A_DIV, 1'b0, d);   check("div_after_reset", d, 8'd25);
        io_read(16'hF9DC, 1'b0, d); check("unselected_read", d, 8'hFF);
        io_read(16'hF8DF, 1'b0, d); check("reg3_read", d, 8'hFF);
        io_read(A_DATA, 1'b1, d);  check("m1_cycle_read", d, 8'hFF);
        io_read(A_DATA, 1'b0, d);  check("empty_rx_read", d, 8'h00);

        // Transmit 8'hA5 at the reset divisor: 416 phi pulses per bit
        io_write(A_DATA, 8'hA5, 1);
        wait_fall(20000, seen, t0);
        check("a5_start_seen", seen, 1'b1);
        for (int i = 0; i < 2000 && txd === 1'b0; i++) @(negedge clk);
        t1 = phi_total;
        check("a5_start_len", t1 - t0, 416);
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            wait_until(t1 + 208 + 416 * i);
            b[i] = txd;
        end
        check("a5_bits", b, 8'hA5);
        wait_until(t1 + 208 + 416 * 8);
        check("a5_stop", txd, 1'b1);
        wait_phi(416);
        check_status("a5_tx_idle");

        // Speed up: 2 phi per tick, 32 phi per bit
        io_write(A_DIV, 8'h01, 1);
        io_read(A_DIV, 1'b0, d);
        check("div_readback", d, 8'h01);
        wait_phi(64);

        // Five frames without reading: four queued, fifth overruns
        for (int v = 8'h11; v <= 8'h15; v++) send_rx(8'(v), 1'b1);
        check_status("overrun_stat");
        drain("overrun");

        // Short low glitch, then a good byte followed by a bad-stop frame
        rxd = 1'b0;
        wait_phi(6);
        rxd = 1'b1;
        wait_phi(64);
        check_status("glitch_stat");
        send_rx(8'h42, 1'b1);
        send_rx(8'h5A, 1'b0);
        check_status("framing_stat");
        drain("framing");

        // Randomized RX rounds against the queue model
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) send_rx(8'($urandom), $urandom_range(0, 4) != 0);
            check_status("rand_rx_stat");
            drain("rand_rx");
        end

        // Held write strobe, second byte while busy, third byte while holding is full
        io_write(A_DATA, 8'h55, 5);
        wait_fall(4000, seen, t1);
        check("b2b_first_seen", seen, 1'b1);
        io_write(A_DATA, 8'h66, 1);
        io_write(A_DATA, 8'h77, 1);
        decode_tx(t1, b1);
        check("b2b_first", b1, 8'h55);
        recv_tx(b2, t2);
        check("b2b_second", b2, 8'h66);
        check("b2b_gap", t2 - t1, 10 * FAST_BIT);
        wait_fall(1600, seen, t0);
        check("b2b_no_third", seen, 1'b0);
        check_status("b2b_idle_stat");

        // Randomized TX bytes
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            io_write(A_DATA, b, 1);
            recv_tx(b1, t1);
            check("rand_tx", b1, b);
        end
        wait_phi(FAST_BIT);

`ifdef CPC_SERIAL_IRQ_EN
        ctrl_write(8'h01);
        check("irq_quiet", bus.irq, 1'b0);
        send_rx(8'h3C, 1'b1);
        check("irq_rx_set", bus.irq, 1'b1);
        check_status("irq_stat");
        io_read(A_DATA, 1'b0, d);
        check("irq_data", d, q.pop_front());
        @(negedge clk);
        check("irq_rx_clear", bus.irq, 1'b0);
        ctrl_write(8'h02);
        check("irq_tx_set", bus.irq, 1'b1);
        ctrl_write(8'h00);
        @(negedge clk);
        check("irq_tx_clear", bus.irq, 1'b0);
`else
        ctrl_write(8'h03);
        send_rx(8'h3C, 1'b1);
        check("irq_tied_low", bus.irq, 1'b0);
        check_status("noirq_stat");
        io_read(A_DATA, 1'b0, d);
        check("noirq_data", d, q.pop_front());
        ctrl_write(8'h00);
`endif

        // Reset in the middle of both a TX and an RX frame
        io_write(A_DATA, 8'($urandom), 1);
        wait_fall(4000, seen, t0);
        check("midreset_tx_seen", seen, 1'b1);
        wait_phi(40);
        rxd = 1'b0;
        wait_phi(50);
        reset = 1'b1;
        #1;
        check("midreset_txd", txd, 1'b1);
        check("midreset_irq", bus.irq, 1'b0);
        @(negedge clk);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        q.delete();
        m_ov = 0; m_fr = 0; m_rxie = 0; m_txie = 0;
        wait_phi(400);
        check("midreset_txd_idle", txd, 1'b1);
        check_status("midreset_stat");
        io_read(A_DIV, 1'b0, d);
        check("midreset_div", d, 8'd25);
        io_read(A_DATA, 1'b0, d);
        check("midreset_empty", d, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpc_serial_card.md
CPC_SERIAL_CARD -- requirements
Module: cpc_serial_card

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on its rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high.
REQ-003 SHALL have ports: phi_en_p  in  1  CPU-phase clock enable (4 MHz), the only timebase.
REQ-004 SHALL have ports: cpu_addr  in  16  Z80 address bus.
REQ-005 SHALL have ports: cpu_dout  in  8  Z80 write data.
REQ-006 SHALL have ports: cpu_din  out  8  read data to the expansion port; 8'hFF when not selected, because the host ANDs this bus.
REQ-007 SHALL have ports: iorq, rd, wr, m1  in  1 each  active-high Z80 strobes.
REQ-008 SHALL have ports: irq  out  1  active-high interrupt request.
REQ-009 SHALL have ports: rxd  in  1  serial input, idle high; txd  out  1  serial output, idle high.

Function
REQ-010 SHALL select when iorq & ~m1 & cpu_addr[15:2]=={8'hF8,6'b110111}; cpu_addr[1:0] is the register index: 0 data, 1 status/control, 2 divisor, 3 reserved.
REQ-011 SHALL drive cpu_din combinationally during selected iorq & rd; reg3 reads 8'hFF; all other times 8'hFF.
REQ-012 SHALL perform each write exactly once per I/O cycle, on the first clk where selected & wr is high, re-armed only after wr drops.
REQ-013 SHALL pop the RX FIFO once per read of reg0, on the clk where selected & rd falls; reading an empty FIFO returns 8'h00 and does not pop.
REQ-014 SHALL generate baud tick every (div+1) phi_en_p pulses; 16 ticks = one bit; div reset 8'd25 (about 9600 baud).
REQ-015 SHALL frame 8N1, LSB first.
REQ-016 RX SHALL synchronise rxd through 2 flops, then run FSM IDLE->START->DATA->STOP->IDLE. START is entered on a low sample; the start bit is re-checked at tick 8 and, if high, the FSM returns to IDLE. Bits are sampled at tick 8 of each bit.
REQ-017 RX SHALL push the byte into a 4-entry FIFO on a valid stop bit. A low stop bit sets framing_err and discards the byte. A push when full sets overrun and discards the byte.
REQ-018 RX SHALL, on a simultaneous push and pop with the FIFO full, accept both with no overrun. FIFO pointers wrap modulo 4.
REQ-019 TX SHALL have a holding register and a shift register. A write to reg0 with the holding register empty loads it; with the holding register full, the write is ignored.
REQ-020 TX FSM IDLE->START->DATA(8)->STOP->IDLE SHALL transfer holding to shift at the next baud-bit boundary when IDLE; back-to-back bytes SHALL have no idle gap.
REQ-021 Status read (reg1) SHALL return: bit0 rx_avail, bit1 tx_hold_empty, bit2 tx_idle, bit3 overrun, bit4 framing_err, bit5 irq, bits7:6 zero.
REQ-022 Control write (reg1) SHALL set: bit0 rx_ie, bit1 tx_ie; bit7=1 clears overrun and framing_err.
REQ-023 Divisor write (reg2) SHALL take effect at the next baud tick without corrupting a frame in progress; reg2 read returns div.
REQ-024 cpu_din timing SHALL be independent of phi_en_p; state changes occur on any clk edge where their condition holds.

Reset
REQ-025 While reset is high SHALL force: FIFO empty, holding empty, both FSMs IDLE, txd=1, irq=0, errors=0, rx_ie=tx_ie=0, div=8'd25, cpu_din=8'hFF when not reading.
REQ-026 Reset mid-frame SHALL abort immediately; txd=1 within the same cycle; no partial byte enters the FIFO.

Configuration
REQ-027 With CPC_SERIAL_IRQ_EN defined, irq SHALL be registered: (rx_ie & rx_avail) | (tx_ie & tx_hold_empty) | overrun, level-held until the cause clears.
REQ-028 Without CPC_SERIAL_IRQ_EN, irq SHALL be tied 0, rx_ie/tx_ie SHALL read back 0, and status bit5 SHALL be 0.

Verification
REQ-029 Reset, then read &F8DD -> 8'h06; read &F8DE -> 8'd25; non-selected read of &F8DC with A15:8=8'hF9 -> 8'hFF.
REQ-030 Write 8'hA5 to &F8DC, div=25 -> txd low 416 phi_en_p pulses, then bits 1,0,1,0,0,1,0,1, then high; tx_idle returns 1.
REQ-031 Drive rxd frames 8'h11..8'h15 without reading -> first 4 queued, overrun=1; reads return 11,12,13,14 then 00; write 8'h80 to &F8DD clears overrun.
REQ-032 rxd low pulse shorter than 8 ticks -> no byte, no framing_err; frame with low stop bit -> framing_err=1, FIFO unchanged.
REQ-033 With CPC_SERIAL_IRQ_EN, write 8'h01 to &F8DD, receive 8'h3C -> irq=1 after stop sample, irq=0 after reading &F8DC; without the macro, irq stays 0.
REQ-034 Wr held high 5 clk on &F8DC with 8'h55 then 8'h66 in next cycle while busy -> only 55 transmitted once, 66 loaded to holding, sent back-to-back.
